// File: rtl/core_run_ctrl.sv
// core_run_ctrl: host-side launcher for core_top.
// Accepts a run request, holds the core in start for START_CYCLES cycles,
// then counts RUN cycles until the core raises done or the optional timeout
// expires. The result is returned over a valid/ready response handshake.
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module core_run_ctrl #(
    parameter int               START_CYCLES = 2,
    parameter int               CNT_W        = 16,
    parameter logic [CNT_W-1:0] TIMEOUT      = CNT_W'(16'hFFFF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [CNT_W-1:0] resp_cycles,
    output logic             resp_timeout,
    output logic             core_start,
    input  logic             core_done,
    output logic             busy,
    output logic [7:0]       run_count
);

    // Start counter only has to hold START_CYCLES (at least 1).
    localparam int SC_W = (START_CYCLES < 2) ? 1 : $clog2(START_CYCLES + 1);

    localparam logic [SC_W-1:0]  START_LOAD = SC_W'(START_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    // A zero TIMEOUT turns the abort path off entirely.
    localparam bit               TIMEOUT_EN = (TIMEOUT != '0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_REPORT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SC_W-1:0]  start_cnt;
    logic [CNT_W-1:0] run_k;
    logic             accept;
    logic             done_hit;
    logic             timeout_hit;
    logic             resp_fire;

    // State register with synchronous reset; reset drops any in-flight run.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its sources.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the single-cycle events the datapath acts on.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_next  = state;
        accept      = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        resp_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                // Last start cycle: the counter was loaded with START_CYCLES.
                if (start_cnt == SC_W'(1)) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Done takes priority over a timeout in the same cycle.
                if (core_done) begin
                    done_hit   = 1'b1;
                    state_next = S_REPORT;
                end else if (TIMEOUT_EN && (run_k == TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_next  = S_REPORT;
                end
            end
            S_REPORT: begin
                if (resp_ready) begin
                    resp_fire  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Start window counter: loaded on accept, counts down while in START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_cnt <= '0;
        end else if (accept) begin
            start_cnt <= START_LOAD;
        end else if (state == S_START) begin
            start_cnt <= start_cnt - SC_W'(1);
        end
    end

    // RUN cycle index k: primed to 1 during START, increments in RUN and
    // saturates at all-ones so a disabled timeout can never wrap it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_k <= '0;
        end else if (state == S_START) begin
            run_k <= CNT_W'(1);
        end else if ((state == S_RUN) && (run_k != CNT_MAX)) begin
            run_k <= run_k + CNT_W'(1);
        end
    end

    // Response registers: captured on leaving RUN, held through REPORT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_cycles  <= '0;
            resp_timeout <= 1'b0;
        end else if (done_hit) begin
            resp_cycles  <= run_k;
            resp_timeout <= 1'b0;
        end else if (timeout_hit) begin
            resp_cycles  <= TIMEOUT;
            resp_timeout <= 1'b1;
        end
    end

    // Successful-run counter: bumps on the handshake of a non-timeout result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_count <= '0;
        end else if (resp_fire && !resp_timeout) begin
            run_count <= run_count + 8'd1;
        end
    end

    // Outputs decoded purely from the state register.
    assign core_start = (state != S_RUN);
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_REPORT);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: self-checking bench for core_run_ctrl.
// Two instances share the stimulus: dut_a with the default timeout and
// dut_b with TIMEOUT=20. A transaction-level model predicts every output of
// both instances each cycle; a vector table and hand sequences add
// hand-computed expectations for the corner cases.
module tb_core_run_ctrl;

    localparam int SC    = 2;
    localparam int CNT_W = 16;
    localparam int TO_A  = 65535;
    localparam int TO_B  = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             req_valid;
    logic             resp_ready;
    logic             core_done;

    logic             a_req_ready, a_resp_valid, a_resp_timeout, a_core_start, a_busy;
    logic [CNT_W-1:0] a_resp_cycles;
    logic [7:0]       a_run_count;
    logic             b_req_ready, b_resp_valid, b_resp_timeout, b_core_start, b_busy;
    logic [CNT_W-1:0] b_resp_cycles;
    logic [7:0]       b_run_count;

    core_run_ctrl #(.START_CYCLES(SC), .CNT_W(CNT_W)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (a_req_ready),
        .resp_valid  (a_resp_valid),
        .resp_ready  (resp_ready),
        .resp_cycles (a_resp_cycles),
        .resp_timeout(a_resp_timeout),
        .core_start  (a_core_start),
        .core_done   (core_done),
        .busy        (a_busy),
        .run_count   (a_run_count)
    );

    core_run_ctrl #(.START_CYCLES(SC), .CNT_W(CNT_W), .TIMEOUT(16'd20)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (b_req_ready),
        .resp_valid  (b_resp_valid),
        .resp_ready  (resp_ready),
        .resp_cycles (b_resp_cycles),
        .resp_timeout(b_resp_timeout),
        .core_start  (b_core_start),
        .core_done   (core_done),
        .busy        (b_busy),
        .run_count   (b_run_count)
    );

    // Transaction-level reference: a run is identified by its accept cycle;
    // the RUN index k is derived arithmetically from the current cycle.
    typedef enum int {PH_IDLE, PH_LAUNCHED, PH_RESULT} phase_e;
    typedef struct {
        phase_e ph;
        int     acc;
        int     rcyc;
        bit     rto;
        int     runs;
    } model_t;

    typedef struct {
        int k;
        int hold;
        bit stale;
        int a_cyc;
        bit a_to;
        int b_cyc;
        bit b_to;
    } vec_t;

    model_t m [2];
    vec_t   tbl [7];
    int     cyc;
    int     checks;
    int     errors;
    int     low_a;
    int     low_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int i, input int lim);
        int k;
        if (!rst_n) begin
            m[i].ph   = PH_IDLE;
            m[i].rcyc = 0;
            m[i].rto  = 1'b0;
            m[i].runs = 0;
        end else begin
            case (m[i].ph)
                PH_IDLE: begin
                    if (req_valid) begin
                        m[i].ph  = PH_LAUNCHED;
                        m[i].acc = cyc;
                    end
                end
                PH_LAUNCHED: begin
                    k = cyc - m[i].acc - SC;
                    if (k >= 1) begin
                        if (core_done) begin
                            m[i].rcyc = (k > 65535) ? 65535 : k;
                            m[i].rto  = 1'b0;
                            m[i].ph   = PH_RESULT;
                        end else if ((lim != 0) && (k == lim)) begin
                            m[i].rcyc = lim;
                            m[i].rto  = 1'b1;
                            m[i].ph   = PH_RESULT;
                        end
                    end
                end
                PH_RESULT: begin
                    if (resp_ready) begin
                        m[i].ph = PH_IDLE;
                        if (!m[i].rto) m[i].runs = (m[i].runs + 1) % 256;
                    end
                end
                default: m[i].ph = PH_IDLE;
            endcase
        end
    endtask

    task automatic compare_inst(input int i, input string p, input logic rr, input logic rv,
                                input logic [CNT_W-1:0] rc, input logic rt, input logic cs,
                                input logic bz, input logic [7:0] cnt);
        bit in_run;
        in_run = (m[i].ph == PH_LAUNCHED) && ((cyc + 1 - m[i].acc - SC) >= 1);
        check({p, ".req_ready"},    32'(rr),  32'(m[i].ph == PH_IDLE));
        check({p, ".resp_valid"},   32'(rv),  32'(m[i].ph == PH_RESULT));
        check({p, ".busy"},         32'(bz),  32'(m[i].ph != PH_IDLE));
        check({p, ".core_start"},   32'(cs),  32'(!in_run));
        check({p, ".resp_cycles"},  32'(rc),  m[i].rcyc);
        check({p, ".resp_timeout"}, 32'(rt),  32'(m[i].rto));
        check({p, ".run_count"},    32'(cnt), m[i].runs);
    endtask

    // One clock: advance the model on the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        cyc++;
        model_step(0, TO_A);
        model_step(1, TO_B);
        #1;
        if (!a_core_start) low_a++;
        if (!b_core_start) low_b++;
        compare_inst(0, "a", a_req_ready, a_resp_valid, a_resp_cycles, a_resp_timeout,
                     a_core_start, a_busy, a_run_count);
        compare_inst(1, "b", b_req_ready, b_resp_valid, b_resp_cycles, b_resp_timeout,
                     b_core_start, b_busy, b_run_count);
    endtask

    // One request: done rises in RUN cycle k, response held for 'hold'
    // cycles with req_valid asserted, then handshaken.
    task automatic run_txn(input int k, input int hold, input bit stale,
                           input int ea_c, input bit ea_t, input int eb_c, input bit eb_t,
                           input string tag);
        int guard;
        if (!stale) core_done = 1'b0;
        low_a = 0;
        low_b = 0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 1; i < SC + k; i++) begin
            step();
            if (stale && (i == 1)) core_done = 1'b0;
        end
        core_done = 1'b1;
        guard = 0;
        while (!(a_resp_valid && b_resp_valid) && (guard < 100)) begin
            step();
            guard++;
        end
        check({tag, ".resp_wait"}, 32'(a_resp_valid && b_resp_valid), 32'd1);
        check({tag, ".a.cycles"},  32'(a_resp_cycles),  ea_c);
        check({tag, ".a.timeout"}, 32'(a_resp_timeout), 32'(ea_t));
        check({tag, ".b.cycles"},  32'(b_resp_cycles),  eb_c);
        check({tag, ".b.timeout"}, 32'(b_resp_timeout), 32'(eb_t));
        check({tag, ".a.start_low"}, low_a, ea_c);
        check({tag, ".b.start_low"}, low_b, eb_c);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            step();
            check({tag, ".hold.a.valid"},  32'(a_resp_valid),  32'd1);
            check({tag, ".hold.a.cycles"}, 32'(a_resp_cycles), ea_c);
            check({tag, ".hold.a.ready"},  32'(a_req_ready),   32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, ".a.req_ready_after"}, 32'(a_req_ready), 32'd1);
        check({tag, ".b.req_ready_after"}, 32'(b_req_ready), 32'd1);
        check({tag, ".a.valid_after"},     32'(a_resp_valid), 32'd0);
    endtask

    initial begin
        int ra;
        int rb;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        core_done  = 1'b0;
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        low_a      = 0;
        low_b      = 0;

        // {k, hold, stale, a_cycles, a_timeout, b_cycles, b_timeout}
        tbl[0] = '{37, 0,  1'b0, 37, 1'b0, 20, 1'b1};  // normal run / timeout
        tbl[1] = '{20, 0,  1'b0, 20, 1'b0, 20, 1'b0};  // done meets timeout
        tbl[2] = '{21, 0,  1'b0, 21, 1'b0, 20, 1'b1};  // one past the limit
        tbl[3] = '{19, 0,  1'b0, 19, 1'b0, 19, 1'b0};  // one before the limit
        tbl[4] = '{1,  0,  1'b0, 1,  1'b0, 1,  1'b0};  // done in first RUN cycle
        tbl[5] = '{12, 10, 1'b0, 12, 1'b0, 12, 1'b0};  // response backpressure
        tbl[6] = '{5,  0,  1'b1, 5,  1'b0, 5,  1'b0};  // stale done from prior run

        // Reset for two cycles, then idle.
        step();
        step();
        rst_n = 1'b1;
        check("reset.core_start",   32'(a_core_start),   32'd1);
        check("reset.req_ready",    32'(a_req_ready),    32'd1);
        check("reset.resp_valid",   32'(a_resp_valid),   32'd0);
        check("reset.run_count",    32'(a_run_count),    32'd0);
        check("reset.busy",         32'(a_busy),         32'd0);
        check("reset.resp_cycles",  32'(a_resp_cycles),  32'd0);
        check("reset.resp_timeout", 32'(a_resp_timeout), 32'd0);

        // Done while idle must not start anything.
        core_done = 1'b1;
        step();
        check("idle_done.busy",      32'(a_busy),      32'd0);
        check("idle_done.req_ready", 32'(a_req_ready), 32'd1);
        core_done = 1'b0;

        ra = 0;
        rb = 0;
        for (int t = 0; t < 7; t++) begin
            run_txn(tbl[t].k, tbl[t].hold, tbl[t].stale, tbl[t].a_cyc, tbl[t].a_to,
                    tbl[t].b_cyc, tbl[t].b_to, $sformatf("vec%0d", t));
            if (!tbl[t].a_to) ra = (ra + 1) % 256;
            if (!tbl[t].b_to) rb = (rb + 1) % 256;
            check($sformatf("vec%0d.a.run_count", t), 32'(a_run_count), ra);
            check($sformatf("vec%0d.b.run_count", t), 32'(b_run_count), rb);
        end

        // Reset asserted at RUN cycle 8.
        core_done = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 1; i < SC + 8; i++) step();
        check("midrst.pre_core_start", 32'(a_core_start), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst.core_start", 32'(a_core_start), 32'd1);
        check("midrst.resp_valid", 32'(a_resp_valid), 32'd0);
        check("midrst.run_count",  32'(a_run_count),  32'd0);
        check("midrst.busy",       32'(a_busy),       32'd0);
        check("midrst.req_ready",  32'(a_req_ready),  32'd1);
        check("midrst.b.run_count", 32'(b_run_count), 32'd0);

        // 256 successful runs wrap the run counter back to zero.
        for (int n = 1; n <= 256; n++) begin
            run_txn(1, 0, 1'b0, 1, 1'b0, 1, 1'b0, "wrap");
            if (n == 255) check("wrap.at255", 32'(a_run_count), 32'd255);
        end
        check("wrap.at256", 32'(a_run_count), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(199, 0) != 0);
            req_valid  = ($urandom_range(3, 0) == 0);
            core_done  = ($urandom_range(15, 0) == 0);
            resp_ready = ($urandom_range(2, 0) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
